// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle signed multiply (shift-add) / divide (restoring) unit with register-file write-back.
module mul_div_unit #(
  parameter int DATA_PATH_WIDTH = 8,
  parameter int ADDR_WIDTH      = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [1:0]                        op,
  input  logic signed [DATA_PATH_WIDTH-1:0] operand_a,
  input  logic signed [DATA_PATH_WIDTH-1:0] operand_b,
  input  logic [ADDR_WIDTH-1:0]             dest_addr,
  output logic                              busy,
  output logic                              done,
  output logic                              wb_wen,
  output logic [ADDR_WIDTH-1:0]             wb_waddr,
  output logic signed [DATA_PATH_WIDTH-1:0] wb_data
);
  localparam int W  = DATA_PATH_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, FIX, WB} state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic                sa_q, sa_d, sb_q, sb_d;
  logic [2*W-1:0]      ma_q, ma_d, acc_q, acc_d;
  logic [W:0]          mb_q, mb_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d;
  logic [W-1:0]        res_q, res_d;

  logic [W:0]   a_ext, b_ext, mag_a, mag_b, shifted;
  logic [W+1:0] diff;
  logic         ge;
  logic [2*W-1:0] prod;
  logic [W-1:0] quo, rem, fix_res;

  // magnitudes are W+1 bits wide so the most negative operand stays positive
  assign a_ext = {operand_a[W-1], operand_a};
  assign b_ext = {operand_b[W-1], operand_b};
  assign mag_a = operand_a[W-1] ? -a_ext : a_ext;
  assign mag_b = operand_b[W-1] ? -b_ext : b_ext;

  // restoring step: ma_q[W-1:0] shifts dividend bits out and quotient bits in, acc_q holds the partial remainder
  assign shifted = {acc_q[W-1:0], ma_q[W-1]};
  assign diff    = {1'b0, shifted} - {1'b0, mb_q};
  assign ge      = ~diff[W+1];

  assign prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo  = (sa_q ^ sb_q) ? -ma_q[W-1:0] : ma_q[W-1:0];
  assign rem  = sa_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  // a zero divisor leaves |a| as the remainder, so only the quotient needs overriding
  assign fix_res = op_q == 2'b00 ? prod[W-1:0] :
                   op_q == 2'b01 ? prod[2*W-1:W] :
                   op_q == 2'b10 ? (mb_q == '0 ? '1 : quo) : rem;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CALC;
        op_d    = op;
        sa_d    = operand_a[W-1];
        sb_d    = operand_b[W-1];
        ma_d    = {{(W-1){1'b0}}, mag_a};
        mb_d    = mag_b;
        acc_d   = '0;
        cnt_d   = '0;
        dest_d  = dest_addr;
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[1]) begin
          acc_d = {{(W-1){1'b0}}, ge ? diff[W:0] : shifted};
          ma_d  = {{W{1'b0}}, ma_q[W-2:0], ge};
        end else begin
          acc_d = acc_q + (mb_q[0] ? ma_q : '0);
          ma_d  = {ma_q[2*W-2:0], 1'b0};
          mb_d  = {1'b0, mb_q[W:1]};
        end
        state_d = cnt_q == CW'(W-1) ? FIX : CALC;
      end
      FIX: begin
        res_d   = fix_res;
        state_d = WB;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      dest_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      res_q   <= res_d;
    end
  end

  assign busy     = state_q != IDLE;
  assign done     = state_q == WB;
  assign wb_wen   = state_q == WB;
  assign wb_waddr = dest_q;
  assign wb_data  = res_q;
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle signed 8-bit multiply/divide unit for the CPU datapath. Sits directly downstream of the register file read ports, taking operands A and B from them. Sits directly upstream of the register file write port, driving its write enable, write address and write data with the result. Handles the MUL/MULH/DIV/REM operations that the single-cycle ALU does not; the control unit stalls on `busy`.

## Interface
Parameters:
- DATA_PATH_WIDTH, 8: operand/result width; behaviour below is specified and verified at 8.
- ADDR_WIDTH, 4: register address width; must match the register file.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MUL (low byte of product), 01 MULH (high byte), 10 DIV (quotient), 11 REM (remainder).
- operand_a  input  signed DATA_PATH_WIDTH  multiplicand / dividend (register file read port A).
- operand_b  input  signed DATA_PATH_WIDTH  multiplier / divisor (register file read port B).
- dest_addr  input  ADDR_WIDTH  destination register for the result.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse, coincident with wb_wen.
- wb_wen  output  1  register file write enable.
- wb_waddr  output  ADDR_WIDTH  register file write address (latched dest_addr).
- wb_data  output  signed DATA_PATH_WIDTH  register file write data.

## Operation
- States:
  - IDLE -> CALC on start.
  - CALC runs 8 iterations, then -> FIX.
  - FIX -> WB.
  - WB -> IDLE.
- Accept, at the edge with state == IDLE and start == 1:
  - latch op and dest_addr;
  - latch sign bits of a and b;
  - latch magnitudes |a| and |b| as 9-bit unsigned, so that -128 becomes 128;
  - clear the 3-bit iteration counter.
- CALC, multiply: unsigned shift-add, one multiplier bit per cycle, into a 16-bit accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, with a 9-bit partial remainder.
- Counter exits CALC after the 8th iteration (count wraps 7 -> 0).
- FIX applies sign correction, written into the result register:
  - MUL/MULH: negate the 16-bit product if the signs differ; MUL = [7:0], MULH = [15:8].
  - DIV: negate the quotient if the signs differ; truncate to 8 bits.
  - REM: the remainder takes the sign of the dividend.
  - Divide by zero (b == 0) overrides: DIV = 0xFF (-1), REM = operand_a unchanged.
  - Overflow -128 / -1: DIV = 0x80 (-128, natural truncation), REM = 0.
- WB: wb_wen = done = 1; wb_waddr = latched dest; wb_data = result.
- start while busy is ignored, including in the WB cycle. Inputs are not re-sampled; operands may change freely after accept.
- All outputs are decoded from registered state; no combinational path from any input to any output.
- Reset, asynchronous and possibly mid-operation, immediately forces:
  - state IDLE;
  - busy = done = wb_wen = 0;
  - wb_waddr = 0, wb_data = 0.
  - The aborted operation produces no write-back.

## Timing
- Accept edge E0. busy rises after E0.
- CALC iterations on E1..E8. FIX on E9.
- wb_wen/done are high for exactly one cycle, between E9 and E10. The register file writes at E10.
- busy falls after E10. Earliest next accept is E11, giving throughput 1 op per 11 cycles.
- Latency is fixed at 10 edges for every op, including divide-by-zero; there is no early termination.
- wb_data and wb_waddr hold their last values after WB until the next FIX/accept. They are only meaningful while wb_wen is high.

## Test plan
- MUL 7 * -3, dest 5:
  - wb_wen is high exactly in the cycle after E9;
  - wb_waddr = 5, wb_data = 0xEB (-21);
  - busy is high for 10 cycles.
- MULH -128 * -128 -> wb_data = 0x40. MUL on the same operands -> 0x00.
- DIV -7 / 2 -> 0xFD (-3). REM -7 / 2 -> 0xFF (-1). REM 7 / -2 -> 0x01.
- Division corner cases:
  - DIV 5 / 0 -> 0xFF; REM 5 / 0 -> 0x05;
  - DIV -128 / -1 -> 0x80; REM -128 / -1 -> 0x00.
- Ignored start: start held high with different op/operands during cycles E1..E10 -> first result unaffected, and exactly one done pulse.
- Reset mid-operation: rst_n pulled low asynchronously at E4 + 1/4 cycle -> busy and wb_wen drop before the next edge, and there is never a write. A new MUL 3 * 4 after reset release -> 0x0C.
